truth_table_sweeper: RTL



---
 rtl/truth_table_sweeper_pkg.sv | 16 +
 rtl/truth_table_sweeper_settle_timer.sv | 39 +++
 rtl/truth_table_sweeper.sv | 107 ++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and helpers for the truth-table sweeper
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int TT_W_DEFAULT = 8;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// rtl/truth_table_sweeper_settle_timer.sv - per-row settle counter with terminal-count pulse
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // terminal count fires on the last held cycle of a row; the counter wraps itself
    assign tc_o = en_i && (cnt_q == LAST);

    // next count: clear on load or wrap, otherwise advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a combinational DUT through every input row and builds its truth-table code
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic                  match
);

    localparam int TT_W = tt_width(N_IN);
    localparam int RW   = N_IN + 1;
    localparam logic [RW-1:0]   LAST_ROW = RW'(TT_W - 1);
    localparam logic [TT_W-1:0] MSB_ONE  = {1'b1, {(TT_W-1){1'b0}}};

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [TT_W-1:0] table_q, table_d;
    logic            match_q, match_d;
    logic            load;
    logic            sweeping;
    logic            tc;
    logic [TT_W-1:0] row_mask;

    assign sweeping = (state_q == SWEEP);
    // row 0 lands in the MSB, so the bit position walks downward as the row rises
    assign row_mask = MSB_ONE >> row_q;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .en_i   (sweeping),
        .tc_o   (tc)
    );

    // sweep FSM: accept start, insert one sample per row, compare once at the end
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        table_d = table_q;
        match_d = match_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    row_d   = '0;
                    table_d = '0;
                    match_d = 1'b0;
                    load    = 1'b1;
                end
            end
            SWEEP: begin
                if (tc) begin
                    table_d = dut_out ? (table_q | row_mask) : (table_q & ~row_mask);
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                        row_d   = '0;
                        match_d = (table_d == expected);
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, row index and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            table_q <= table_d;
            match_q <= match_d;
        end
    end

    assign busy      = sweeping;
    assign done      = (state_q == DONE);
    assign dut_in    = row_q[N_IN-1:0];
    assign table_out = table_q;
    assign match     = match_q;

endmodule
